// File: rtl/bcd_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_clk_pkg
// Description : Shared types and constants for the BCD clock scan controller.
// Revision    : 1.0
// ============================================================================
package bcd_clk_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV_H  = 3'd1,
    CONV_M  = 3'd2,
    CONV_S  = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  localparam int         NUM_DIGITS = 6;
  localparam logic [7:0] MAX_FIELD  = 8'd99;

  typedef logic [2:0] digit_idx_t;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [5:0] an_onehot_n(input digit_idx_t idx);
    return ~(6'b000001 << idx);
  endfunction

endpackage : bcd_clk_pkg
`default_nettype wire

// File: rtl/bcd_scan_ctrl_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_ctrl_conv
// Description : Combinational binary-to-BCD converter, 8-bit in, tens/ones out.
// Revision    : 1.0
// ============================================================================
module bcd_scan_ctrl_conv (
  input  logic [7:0] bin,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  // Inputs are clamped upstream to 0..99, so the quotient fits a nibble.
  assign tens = 4'(bin / 8'd10);
  assign ones = 4'(bin % 8'd10);

endmodule : bcd_scan_ctrl_conv
`default_nettype wire

// File: rtl/bcd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_ctrl
// Description : Snapshots hh:mm:ss, converts to BCD via one shared converter,
//               publishes atomically and scans six multiplexed digits.
//               Optional macro BCD_LEADING_BLANK_EN blanks a zero hours-tens.
// Revision    : 1.0
// ============================================================================
module bcd_scan_ctrl
  import bcd_clk_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update_req,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  output logic       busy,
  output logic       done,
  output logic       range_err,
  output logic [3:0] digit,
  output logic [5:0] an_n
);

  localparam logic [15:0] c_div_last = 16'(SCAN_DIV - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_pending;
  logic        w_pending_next;
  logic        w_take_snap;
  logic [7:0]  r_snap_h;
  logic [7:0]  r_snap_m;
  logic [7:0]  r_snap_s;
  logic        r_range_err;

  logic [7:0]  w_field;
  logic        w_over;
  logic [7:0]  w_field_clamped;
  logic [3:0]  w_ones;
  logic [3:0]  w_tens;

  logic [3:0]  r_shadow [NUM_DIGITS];
  logic [3:0]  r_disp   [NUM_DIGITS];

  logic [15:0] r_presc;
  logic        w_wrap;
  digit_idx_t  r_idx;
  digit_idx_t  w_idx_next;
  logic [3:0]  w_scan_digit;
  logic [5:0]  w_an_next;
  logic [3:0]  r_digit;
  logic [5:0]  r_an_n;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_take_snap    = 1'b0;
    case (r_state)
      IDLE: begin
        if (update_req) begin
          w_state_next = CONV_H;
          w_take_snap  = 1'b1;
        end
      end
      CONV_H: begin
        w_state_next = CONV_M;
        if (update_req) w_pending_next = 1'b1;
      end
      CONV_M: begin
        w_state_next = CONV_S;
        if (update_req) w_pending_next = 1'b1;
      end
      CONV_S: begin
        w_state_next = PUBLISH;
        if (update_req) w_pending_next = 1'b1;
      end
      PUBLISH: begin
        // A request arriving in this very cycle is serviced like a pending one.
        if (r_pending || update_req) begin
          w_state_next   = CONV_H;
          w_take_snap    = 1'b1;
          w_pending_next = 1'b0;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == PUBLISH);
  assign range_err = r_range_err;

  // ---------------------------------------------------------------------------
  // Snapshot, clamp and time-shared conversion
  // ---------------------------------------------------------------------------
  always_comb begin
    w_field = r_snap_s;
    case (r_state)
      CONV_H:  w_field = r_snap_h;
      CONV_M:  w_field = r_snap_m;
      default: w_field = r_snap_s;
    endcase
  end

  assign w_over          = (w_field > MAX_FIELD);
  assign w_field_clamped = w_over ? MAX_FIELD : w_field;

  bcd_scan_ctrl_conv u_conv (
    .bin  (w_field_clamped),
    .ones (w_ones),
    .tens (w_tens)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_h    <= '0;
      r_snap_m    <= '0;
      r_snap_s    <= '0;
      r_range_err <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_disp[i]   <= '0;
      end
    end else begin
      if (w_take_snap) begin
        r_snap_h <= hours;
        r_snap_m <= minutes;
        r_snap_s <= seconds;
      end
      case (r_state)
        CONV_H: begin
          r_shadow[5] <= w_tens;
          r_shadow[4] <= w_ones;
        end
        CONV_M: begin
          r_shadow[3] <= w_tens;
          r_shadow[2] <= w_ones;
        end
        CONV_S: begin
          r_shadow[1] <= w_tens;
          r_shadow[0] <= w_ones;
        end
        PUBLISH: begin
          for (int i = 0; i < NUM_DIGITS; i++) r_disp[i] <= r_shadow[i];
        end
        default: ;
      endcase
      if ((r_state == CONV_H || r_state == CONV_M || r_state == CONV_S) && w_over)
        r_range_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Free-running digit scan
  // ---------------------------------------------------------------------------
  assign w_wrap = (r_presc == c_div_last);

  always_comb begin
    w_idx_next = r_idx;
    if (w_wrap) w_idx_next = (r_idx == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : r_idx + 3'd1;
  end

  always_comb begin
    w_scan_digit = r_disp[0];
    case (w_idx_next)
      3'd1:    w_scan_digit = r_disp[1];
      3'd2:    w_scan_digit = r_disp[2];
      3'd3:    w_scan_digit = r_disp[3];
      3'd4:    w_scan_digit = r_disp[4];
      3'd5:    w_scan_digit = r_disp[5];
      default: w_scan_digit = r_disp[0];
    endcase
  end

`ifdef BCD_LEADING_BLANK_EN
  always_comb begin
    w_an_next = an_onehot_n(w_idx_next);
    if (w_idx_next == 3'd5 && r_disp[5] == 4'd0) w_an_next = 6'b111111;
  end
`else
  assign w_an_next = an_onehot_n(w_idx_next);
`endif

  // digit and an_n are both derived from w_idx_next so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_digit <= '0;
      r_an_n  <= 6'b111110;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 16'd1;
      r_idx   <= w_idx_next;
      r_digit <= w_scan_digit;
      r_an_n  <= w_an_next;
    end
  end

  assign digit = r_digit;
  assign an_n  = r_an_n;

endmodule : bcd_scan_ctrl
`default_nettype wire
